// File: rtl/pipe_stage_elastic_if.sv
// Valid/ready bundle for one side of an elastic stage.
// master drives valid/data/pc/bd; slave drives ready.
interface pipe_stage_elastic_if #(
  parameter int DATA_W = 192,
  parameter int PC_W   = 32
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [PC_W-1:0]   pc;
  logic              bd;

  modport master (
    output valid, data, pc, bd,
    input  ready
  );

  modport slave (
    input  valid, data, pc, bd,
    output ready
  );
endinterface

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register with a one-entry skid buffer.
// Ports: Clk, Rst (sync, high), flush, up (slave), dn (master), stall_cnt.
module pipe_stage_elastic #(
  parameter int          DATA_W        = 192,
  parameter int          PC_W          = 32,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter bit          FLUSH_KEEP_PC = 1'b1,
  parameter int          CNT_W         = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 flush,
  pipe_stage_elastic_if.slave  up,
  pipe_stage_elastic_if.master dn,
  output logic [CNT_W-1:0]     stall_cnt
);

  // state bits double as {skid_valid, main_valid}
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b01,
    SKID  = 2'b11
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [PC_W-1:0]   main_pc, skid_pc;
  logic              main_bd, skid_bd;
  logic              main_valid, skid_valid;
  logic              accept, consume;

  assign main_valid = state[0];
  assign skid_valid = state[1];

  // in_ready is the inverted skid flop: no path from dn.ready
  assign up.ready = ~skid_valid;
  assign accept   = up.valid & up.ready;
  assign consume  = main_valid & dn.ready;

  assign dn.valid = main_valid;
  assign dn.data  = main_data;
  assign dn.pc    = main_pc;
  assign dn.bd    = main_bd;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= EMPTY;
      main_data <= '0;
      main_pc   <= RESET_PC;
      main_bd   <= 1'b0;
      skid_data <= '0;
      skid_pc   <= RESET_PC;
      skid_bd   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (main_valid && !dn.ready && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
      if (flush) begin
        state     <= EMPTY;
        main_data <= '0;
        main_bd   <= 1'b0;
        skid_data <= '0;
        skid_pc   <= RESET_PC;
        skid_bd   <= 1'b0;
        if (!FLUSH_KEEP_PC)
          main_pc <= RESET_PC;
      end else begin
        unique case (state)
          EMPTY: begin
            if (accept) begin
              main_data <= up.data;
              main_pc   <= up.pc;
              main_bd   <= up.bd;
              state     <= FULL;
            end
          end
          FULL: begin
            if (consume && accept) begin
              main_data <= up.data;
              main_pc   <= up.pc;
              main_bd   <= up.bd;
            end else if (consume) begin
              state <= EMPTY;
            end else if (accept) begin
              skid_data <= up.data;
              skid_pc   <= up.pc;
              skid_bd   <= up.bd;
              state     <= SKID;
            end
          end
          SKID: begin
            if (consume) begin
              main_data <= skid_data;
              main_pc   <= skid_pc;
              main_bd   <= skid_bd;
              state     <= FULL;
            end
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic: three instances share stimulus
// (keep-PC, reset-PC-on-flush, 4-bit counter).
module tb_pipe_stage_elastic;

  localparam int DW = 32;
  localparam int PW = 32;
  localparam logic [31:0] RPC = 32'h3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, flush, iv, ibd, ordy;
  logic [PW-1:0] ipc;
  logic [DW-1:0] idata;
  logic [15:0]   cnt0, cnt1;
  logic [3:0]    cnt2;

  pipe_stage_elastic_if #(.DATA_W(DW), .PC_W(PW)) up0 ();
  pipe_stage_elastic_if #(.DATA_W(DW), .PC_W(PW)) up1 ();
  pipe_stage_elastic_if #(.DATA_W(DW), .PC_W(PW)) up2 ();
  pipe_stage_elastic_if #(.DATA_W(DW), .PC_W(PW)) dn0 ();
  pipe_stage_elastic_if #(.DATA_W(DW), .PC_W(PW)) dn1 ();
  pipe_stage_elastic_if #(.DATA_W(DW), .PC_W(PW)) dn2 ();

  assign up0.valid = iv;  assign up1.valid = iv;  assign up2.valid = iv;
  assign up0.pc = ipc;    assign up1.pc = ipc;    assign up2.pc = ipc;
  assign up0.data = idata; assign up1.data = idata; assign up2.data = idata;
  assign up0.bd = ibd;    assign up1.bd = ibd;    assign up2.bd = ibd;
  assign dn0.ready = ordy; assign dn1.ready = ordy; assign dn2.ready = ordy;

  pipe_stage_elastic #(.DATA_W(DW), .PC_W(PW), .RESET_PC(RPC),
    .FLUSH_KEEP_PC(1'b1), .CNT_W(16)) u0 (
    .Clk(clk), .Rst(rst), .flush(flush),
    .up(up0), .dn(dn0), .stall_cnt(cnt0));

  pipe_stage_elastic #(.DATA_W(DW), .PC_W(PW), .RESET_PC(RPC),
    .FLUSH_KEEP_PC(1'b0), .CNT_W(16)) u1 (
    .Clk(clk), .Rst(rst), .flush(flush),
    .up(up1), .dn(dn1), .stall_cnt(cnt1));

  pipe_stage_elastic #(.DATA_W(DW), .PC_W(PW), .RESET_PC(RPC),
    .FLUSH_KEEP_PC(1'b1), .CNT_W(4)) u2 (
    .Clk(clk), .Rst(rst), .flush(flush),
    .up(up2), .dn(dn2), .stall_cnt(cnt2));

  typedef struct {
    logic        rst, flush, iv;
    logic [31:0] pc, data;
    logic        bd, ordy;
    logic        ov;
    logic [31:0] opc, opc1, odata;
    logic        obd, ir;
    int          cnt;
  } vec_t;

  vec_t vecs[$];
  int   passed = 0;
  int   total  = 0;

  function automatic logic [31:0] dat(input logic [31:0] pc);
    return {16'hDA7A, pc[15:0]};
  endfunction

  function automatic int sat4(input int c);
    return (c > 15) ? 15 : c;
  endfunction

  task automatic add(input logic r, f, v, input logic [31:0] pc, d,
                     input logic b, rdy, eov, input logic [31:0] epc,
                     epc1, ed, input logic ebd, eir, input int ec);
    vec_t t;
    t.rst = r; t.flush = f; t.iv = v; t.pc = pc; t.data = d;
    t.bd = b; t.ordy = rdy; t.ov = eov; t.opc = epc; t.opc1 = epc1;
    t.odata = ed; t.obd = ebd; t.ir = eir; t.cnt = ec;
    vecs.push_back(t);
  endtask

  task automatic chk(input string nm, input int idx,
                     input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s step %0d: got %0h expected %0h",
                  nm, idx, act, exp);
  endtask

  task automatic drive(input logic r, f, v, input logic [31:0] pc, d,
                       input logic b, rdy);
    rst = r; flush = f; iv = v; ipc = pc; idata = d; ibd = b; ordy = rdy;
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // reset
    add(1,0,0, 0,0,0,0, 0,RPC,RPC,0,0,1,0);
    // full-rate stream, latency 1
    for (int k = 0; k < 8; k++) begin
      logic [31:0] p;
      logic        b;
      p = 32'h3000 + 32'(4 * k);
      b = k[0];
      add(0,0,1, p,dat(p),b,1, 1,p,p,dat(p),b,1,0);
    end
    add(0,0,0, 0,0,0,1, 0,32'h301C,32'h301C,dat(32'h301C),1,1,0);
    // back-pressure: A, B into skid, C held upstream
    add(0,0,1, 32'h3100,dat(32'h3100),0,1, 1,32'h3100,32'h3100,dat(32'h3100),0,1,0);
    add(0,0,1, 32'h3104,dat(32'h3104),0,0, 1,32'h3100,32'h3100,dat(32'h3100),0,0,1);
    add(0,0,1, 32'h3108,dat(32'h3108),0,0, 1,32'h3100,32'h3100,dat(32'h3100),0,0,2);
    add(0,0,1, 32'h3108,dat(32'h3108),0,0, 1,32'h3100,32'h3100,dat(32'h3100),0,0,3);
    add(0,0,1, 32'h3108,dat(32'h3108),0,1, 1,32'h3104,32'h3104,dat(32'h3104),0,1,3);
    add(0,0,1, 32'h3108,dat(32'h3108),0,1, 1,32'h3108,32'h3108,dat(32'h3108),0,1,3);
    add(0,0,0, 0,0,0,1, 0,32'h3108,32'h3108,dat(32'h3108),0,1,3);
    // flush while in SKID, main pc 0x3010
    add(0,0,1, 32'h3010,dat(32'h3010),1,1, 1,32'h3010,32'h3010,dat(32'h3010),1,1,3);
    add(0,0,1, 32'h3014,dat(32'h3014),1,0, 1,32'h3010,32'h3010,dat(32'h3010),1,0,4);
    add(0,1,1, 32'h3018,dat(32'h3018),1,0, 0,32'h3010,RPC,0,0,1,5);
    add(0,0,0, 0,0,0,0, 0,32'h3010,RPC,0,0,1,5);
    // Rst together with flush mid-stream
    add(0,0,1, 32'h3020,dat(32'h3020),0,1, 1,32'h3020,32'h3020,dat(32'h3020),0,1,5);
    add(1,1,1, 32'h3024,dat(32'h3024),1,1, 0,RPC,RPC,0,0,1,0);
    add(0,0,1, 32'h3200,dat(32'h3200),1,1, 1,32'h3200,32'h3200,dat(32'h3200),1,1,0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].flush, vecs[i].iv, vecs[i].pc,
            vecs[i].data, vecs[i].bd, vecs[i].ordy);
      @(posedge clk);
      #1;
      chk("out_valid", i, 64'(dn0.valid), 64'(vecs[i].ov));
      chk("out_pc",    i, 64'(dn0.pc),    64'(vecs[i].opc));
      chk("out_data",  i, 64'(dn0.data),  64'(vecs[i].odata));
      chk("out_bd",    i, 64'(dn0.bd),    64'(vecs[i].obd));
      chk("in_ready",  i, 64'(up0.ready), 64'(vecs[i].ir));
      chk("stall_cnt", i, 64'(cnt0),      64'(vecs[i].cnt));
      chk("pc_nokeep", i, 64'(dn1.pc),    64'(vecs[i].opc1));
      chk("cnt4",      i, 64'(cnt2),      64'(sat4(vecs[i].cnt)));
    end

    // saturation: hold main 0x3200 under 20 stalled cycles
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    chk("sat_cnt4",  100, 64'(cnt2),      64'd15);
    chk("sat_cnt16", 100, 64'(cnt0),      64'd20);
    chk("sat_hold",  100, 64'(dn0.pc),    64'h3200);
    chk("sat_valid", 100, 64'(dn0.valid), 64'd1);
    // flush does not clear the counter
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("fl_cnt4",   101, 64'(cnt2),      64'd15);
    chk("fl_cnt16",  101, 64'(cnt0),      64'd21);
    chk("fl_valid",  101, 64'(dn0.valid), 64'd0);
    @(posedge clk);
    #1;
    chk("idle_cnt4", 102, 64'(cnt2),      64'd15);
    chk("idle_cnt16",102, 64'(cnt0),      64'd21);
    // only Rst clears it
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_cnt4",  103, 64'(cnt2),      64'd0);
    chk("rst_cnt16", 103, 64'(cnt0),      64'd0);
    chk("rst_ready", 103, 64'(up0.ready), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
